// File: rtl/riscv_fetch_queue.sv
// LFSR-driven RISC-V instruction generator feeding a DEPTH-entry FIFO; 1-cycle generate-to-head latency.
// out_ready=0 holds the head and freezes generation once full; flush empties the queue and redirects the PC.
module riscv_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] SEED     = 32'hDEADC0DE,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              fetched_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;
  logic [31:0]       r_lfsr;
  logic [31:0]       r_pc;
  logic [31:0]       r_fetched;

  logic              w_pop;
  logic              w_push;
  logic [31:0]       w_lfsr_next;
  logic [6:0]        w_opcode;
  logic [31:0]       w_instr;
  fq_entry_t         w_head;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign count         = r_count;
  assign fetched_count = r_fetched;

  // Flush wins over both sides; a full queue may still push when its head leaves this cycle.
  assign w_pop  = out_valid & out_ready & ~flush;
  assign w_push = rst_n & ~flush & ((r_count < FULL_CNT) | w_pop);

  assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

  always_comb begin
    w_opcode = 7'b0110011;
    case (r_lfsr[1:0])
      2'b00:   w_opcode = 7'b0110011;
      2'b01:   w_opcode = 7'b0010011;
      2'b10:   w_opcode = 7'b0110111;
      default: w_opcode = 7'b0110011;
    endcase
  end

  assign w_instr = {r_lfsr[31:7], w_opcode};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{instr: w_instr, pc: r_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_lfsr    <= SEED;
      r_pc      <= RESET_PC;
      r_fetched <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_pc     <= flush_pc;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_pc      <= r_pc + 32'd4;
        r_lfsr    <= w_lfsr_next;
        r_fetched <= r_fetched + 32'd1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: hand-derived LFSR stream, backpressure, flush and mid-stream reset.
module tb_riscv_fetch_queue;

  // Stream from SEED 32'hDEADC0DE, in push order.
  localparam logic [31:0] I1 = 32'hDEADC0B7;
  localparam logic [31:0] I2 = 32'hBD5B8193;
  localparam logic [31:0] I3 = 32'h7AB70337;
  localparam logic [31:0] I4 = 32'hF56E06B3;
  localparam logic [31:0] I5 = 32'hEADC0DB3;
  localparam logic [31:0] I6 = 32'hD5B81B93;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;
  logic [31:0] fetched_count;

  int vectors     = 0;
  int miscompares = 0;

  riscv_fetch_queue #(
    .DEPTH    (4),
    .SEED     (32'hDEADC0DE),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .count         (count),
    .fetched_count (fetched_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_empty(input string tag, input logic [31:0] fc);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".fetched"}, fetched_count, fc);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] cnt, input logic [31:0] fc);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".instr"}, out_instr, instr);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".count"}, 32'(count), cnt);
    chk({tag, ".fetched"}, fetched_count, fc);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_empty("reset", 32'd0);

    // Streaming with the decode stage always ready: one per cycle, occupancy stays at 1.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_head("stream0", I1, 32'h0, 32'd1, 32'd1);
    tick();
    chk_head("stream1", I2, 32'h4, 32'd1, 32'd2);
    tick();
    chk_head("stream2", I3, 32'h8, 32'd1, 32'd3);

    out_ready = 1'b0;
    tick();
    chk_head("stall2", I3, 32'h8, 32'd2, 32'd4);

    // One-cycle reset with two entries queued.
    rst_n = 1'b0;
    tick();
    chk_empty("midreset", 32'd0);

    // Backpressure from release: fill to DEPTH, then generation freezes.
    rst_n = 1'b1;
    tick();
    chk_head("fill1", I1, 32'h0, 32'd1, 32'd1);
    tick();
    tick();
    tick();
    chk_head("fill4", I1, 32'h0, 32'd4, 32'd4);
    tick();
    chk_head("fullhold", I1, 32'h0, 32'd4, 32'd4);

    // Pop and push in the same cycle while full.
    out_ready = 1'b1;
    tick();
    chk_head("fullpop", I2, 32'h4, 32'd4, 32'd5);
    tick();
    chk_head("drain8", I3, 32'h8, 32'd4, 32'd6);
    tick();
    chk_head("drain12", I4, 32'hC, 32'd4, 32'd7);
    tick();
    chk_head("drain16", I5, 32'h10, 32'd4, 32'd8);

    // Restart, reach count=3 after four pushes, then flush.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_empty("reset2", 32'd0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    tick();
    chk_head("pre1", I2, 32'h4, 32'd1, 32'd2);
    out_ready = 1'b0;
    tick();
    tick();
    chk_head("pre3", I2, 32'h4, 32'd3, 32'd4);

    flush    = 1'b1;
    flush_pc = 32'h0000_1000;
    tick();
    chk_empty("flush3", 32'd4);
    flush = 1'b0;
    tick();
    chk_head("postflush", I5, 32'h1000, 32'd1, 32'd5);

    // Flush with a ready consumer and a pending push, then a second flush back to back.
    out_ready = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h0000_2000;
    tick();
    chk_empty("flushrdy", 32'd5);
    flush_pc = 32'h0000_3000;
    tick();
    chk_empty("flush2x", 32'd5);
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_head("postflush2", I6, 32'h3000, 32'd1, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
